// File: rtl/reservation_station_pkg.sv
// Shared opcode/funct3 encodings and the branch-compare helper for the ALU reservation station.
package reservation_station_pkg;

  localparam int DATA_W    = 32;
  localparam int ROB_TAG_W = 4;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] B_TYPE = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
    logic taken;
    case (f3)
      F3_BEQ:  taken = (a == b);
      F3_BNE:  taken = (a != b);
      F3_BLT:  taken = ($signed(a) < $signed(b));
      F3_BGE:  taken = ($signed(a) >= $signed(b));
      F3_BLTU: taken = (a < b);
      F3_BGEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/reservation_station_alu.sv
// Combinational ALU for the reservation station: arithmetic/logic ops and branch condition evaluation.
module reservation_station_alu
  import reservation_station_pkg::*;
(
  input  logic [6:0]        op_type_i,
  input  logic [2:0]        op_i,
  input  logic              alt_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = {DATA_W{1'b0}};
    if (op_type_i == B_TYPE) begin
      result_o = {{(DATA_W-1){1'b0}}, branch_taken(op_i, a_i, b_i)};
    end else begin
      case (op_i)
        // SUB only exists for register-register ops; ADDI has no alternate form
        F3_ADD:  result_o = (alt_i && (op_type_i == R_TYPE)) ? (a_i - b_i) : (a_i + b_i);
        F3_SLL:  result_o = a_i << shamt;
        F3_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
        F3_SLTU: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
        F3_XOR:  result_o = a_i ^ b_i;
        F3_SR:   result_o = alt_i ? DATA_W'($signed(a_i) >>> shamt) : (a_i >> shamt);
        F3_OR:   result_o = a_i | b_i;
        F3_AND:  result_o = a_i & b_i;
        default: result_o = {DATA_W{1'b0}};
      endcase
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers issued ops, snoops own and LSB broadcasts, and executes
// the lowest-index ready entry each cycle, broadcasting its result to the ROB.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE = 8,
  parameter int ROB_BIT = ROB_TAG_W
)(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear_up,
  output logic               rs_full,
  input  logic               issue_valid,
  input  logic [6:0]         issue_op_type,
  input  logic [2:0]         issue_op,
  input  logic               issue_alt,
  input  logic [ROB_BIT-1:0] issue_rob_entry,
  input  logic [31:0]        issue_vj,
  input  logic [31:0]        issue_vk,
  input  logic [ROB_BIT-1:0] issue_qj,
  input  logic [ROB_BIT-1:0] issue_qk,
  input  logic               issue_rj,
  input  logic               issue_rk,
  input  logic [31:0]        issue_imm,
  input  logic               lsb_ready_bd,
  input  logic [ROB_BIT-1:0] lsb_rob_entry,
  input  logic [31:0]        lsb_value,
  output logic               rs_ready_bd,
  output logic [ROB_BIT-1:0] rs_rob_entry,
  output logic [31:0]        rs_value
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy_q;
  logic [RS_SIZE-1:0] rj_q;
  logic [RS_SIZE-1:0] rk_q;
  logic [6:0]         type_q [RS_SIZE];
  logic [2:0]         op_q   [RS_SIZE];
  logic               alt_q  [RS_SIZE];
  logic [ROB_BIT-1:0] rob_q  [RS_SIZE];
  logic [ROB_BIT-1:0] qj_q   [RS_SIZE];
  logic [ROB_BIT-1:0] qk_q   [RS_SIZE];
  logic [31:0]        vj_q   [RS_SIZE];
  logic [31:0]        vk_q   [RS_SIZE];

  logic               bd_q;
  logic [ROB_BIT-1:0] tag_q;
  logic [31:0]        val_q;

  logic [RS_SIZE-1:0] ready_vec;
  logic [RS_SIZE-1:0] wake_j;
  logic [RS_SIZE-1:0] wake_k;
  logic [31:0]        wake_j_val [RS_SIZE];
  logic [31:0]        wake_k_val [RS_SIZE];
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [31:0]        alu_res;
  logic               iss_rj_d;
  logic               iss_rk_d;
  logic [31:0]        iss_vj_d;
  logic [31:0]        iss_vk_d;

  function automatic logic [IDX_W:0] first_set(input logic [RS_SIZE-1:0] vec);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (vec[i]) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  // Own broadcast takes precedence over the LSB broadcast when both carry the same tag.
  function automatic logic [32:0] snoop(input logic [ROB_BIT-1:0] q);
    logic [32:0] res;
    if (bd_q && (tag_q == q))                          res = {1'b1, val_q};
    else if (lsb_ready_bd && (lsb_rob_entry == q))     res = {1'b1, lsb_value};
    else                                               res = 33'd0;
    return res;
  endfunction

  assign ready_vec               = busy_q & rj_q & rk_q;
  assign {free_found, free_idx}  = first_set(~busy_q);
  assign {sel_found, sel_idx}    = first_set(ready_vec);
  assign rs_full                 = &busy_q;
  assign rs_ready_bd             = bd_q;
  assign rs_rob_entry            = tag_q;
  assign rs_value                = val_q;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      {wake_j[i], wake_j_val[i]} = snoop(qj_q[i]);
      {wake_k[i], wake_k_val[i]} = snoop(qk_q[i]);
    end
  end

  always_comb begin
    iss_vj_d = issue_vj;
    iss_rj_d = 1'b1;
    if (!issue_rj) begin
      {iss_rj_d, iss_vj_d} = snoop(issue_qj);
    end else begin
      iss_vj_d = issue_vj;
    end
    iss_vk_d = issue_vk;
    iss_rk_d = 1'b1;
    if (issue_op_type == I_TYPE) begin
      iss_vk_d = issue_imm;
    end else if (!issue_rk) begin
      {iss_rk_d, iss_vk_d} = snoop(issue_qk);
    end else begin
      iss_vk_d = issue_vk;
    end
  end

  reservation_station_alu u_alu (
    .op_type_i (type_q[sel_idx]),
    .op_i      (op_q[sel_idx]),
    .alt_i     (alt_q[sel_idx]),
    .a_i       (vj_q[sel_idx]),
    .b_i       (vk_q[sel_idx]),
    .result_o  (alu_res)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && clear_up)) begin
      busy_q <= '0;
      bd_q   <= 1'b0;
      tag_q  <= '0;
      val_q  <= 32'd0;
    end else if (rdy_in) begin
      bd_q <= sel_found;
      if (sel_found) begin
        tag_q <= rob_q[sel_idx];
        val_q <= alu_res;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && !rj_q[i] && wake_j[i]) begin
          vj_q[i] <= wake_j_val[i];
          rj_q[i] <= 1'b1;
        end
        if (busy_q[i] && !rk_q[i] && wake_k[i]) begin
          vk_q[i] <= wake_k_val[i];
          rk_q[i] <= 1'b1;
        end
      end
      if (sel_found) busy_q[sel_idx] <= 1'b0;
      // The free slot comes from the pre-edge busy vector, so a slot freed this edge stays unused.
      if (issue_valid && free_found) begin
        busy_q[free_idx] <= 1'b1;
        type_q[free_idx] <= issue_op_type;
        op_q[free_idx]   <= issue_op;
        alt_q[free_idx]  <= issue_alt;
        rob_q[free_idx]  <= issue_rob_entry;
        qj_q[free_idx]   <= issue_qj;
        qk_q[free_idx]   <= issue_qk;
        vj_q[free_idx]   <= iss_vj_d;
        vk_q[free_idx]   <= iss_vk_d;
        rj_q[free_idx]   <= iss_rj_d;
        rk_q[free_idx]   <= iss_rk_d;
      end
    end
  end

endmodule
